addsub_arbiter: RTL



---
 rtl/addsub_arbiter_pkg.sv | 24 ++
 rtl/addsub_arbiter_if.sv | 47 ++++
 rtl/addsub_arbiter_addsub_unit.sv | 31 +++
 rtl/addsub_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared constants, types and the arbitration rule for the add/sub arbiter.
package addsub_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Round-robin choice between two requesters: a lone requester wins,
    // contention goes to the one not granted last time.
    function automatic logic pick_grant(input logic valid0, input logic valid1,
                                        input logic last);
        if (valid0 && valid1) begin
            return !last;
        end
        return valid1;
    endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two client engines, the arbiter and the consumer.
interface addsub_arbiter_if
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             req0_valid;
    logic             req0_ready;
    logic             req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_ovf;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf,
        input  rsp_ready
    );

    // Requester/consumer side.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf,
        output rsp_ready
    );

endinterface

// File: rtl/addsub_arbiter_addsub_unit.sv
// Combinational WIDTH-bit ripple-carry adder/subtractor built from full-adder cells.
// Subtract is a + ~b + 1, so cout = 1 on subtract means no borrow.
module addsub_unit
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;

    assign b_eff    = b ^ {WIDTH{op}};
    assign carry[0] = op;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign result[i]  = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign cout = carry[WIDTH];
    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter sharing one add/sub datapath, with a
// single-entry registered response slot tagged by requester id.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH  // must match the interface instance
) (
    input  logic             clk,
    input  logic             rst,
    addsub_arbiter_if.slave  bus
);

    slot_state_e      state_q, state_d;
    logic             last_q, last_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    logic             grant_id;
    logic             can_accept;
    logic             ready0;
    logic             ready1;
    logic             xfer;

    logic             sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_ovf;

    // Grant, slot availability and the per-requester ready handshake.
    always_comb begin
        // NOTE: every signal gets a value on every path through always_comb,
        // otherwise synthesis infers a latch to hold the old value.
        grant_id   = pick_grant(bus.req0_valid, bus.req1_valid, last_q);
        can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;
        ready0     = !rst && can_accept && bus.req0_valid && (grant_id == 1'b0);
        ready1     = !rst && can_accept && bus.req1_valid && (grant_id == 1'b1);
        xfer       = ready0 || ready1;
        sel_op     = grant_id ? bus.req1_op : bus.req0_op;
        sel_a      = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b      = grant_id ? bus.req1_b  : bus.req0_b;
    end

    addsub_unit #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a      (sel_a),
        .b      (sel_b),
        .op     (sel_op),
        .result (alu_result),
        .cout   (alu_cout),
        .ovf    (alu_ovf)
    );

    // Next state of the slot FSM, its payload and the round-robin pointer.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ovf_d    = rsp_ovf_q;
        if (xfer) begin
            // A consume on the same edge is absorbed: overwrite, stay FULL.
            state_d      = ST_FULL;
            last_d       = grant_id;
            rsp_id_d     = grant_id;
            rsp_result_d = alu_result;
            rsp_cout_d   = alu_cout;
            rsp_ovf_d    = alu_ovf;
        end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Slot FSM and registered response outputs.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q      <= ST_EMPTY;
            last_q       <= 1'b1;   // requester 0 wins the first contention
            // NOTE: the payload is reset too because it is directly visible
            // on the outputs; a buried data register could skip this.
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_ovf    = rsp_ovf_q;

endmodule
